// File: rtl/dotprod_acc.sv
// dotprod_acc: streams two SRAM vectors and returns their inner product.
// Signed/unsigned build, run-time saturating or wrapping accumulate.
module dotprod_acc #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32,
  parameter int ACC_W  = 64,
  parameter int SIGNED = 1
) (
  input  logic              ap_clk,
  input  logic              ap_rst,
  input  logic              ap_start,
  output logic              ap_idle,
  output logic              ap_done,
  output logic [ACC_W-1:0]  ap_return,
  output logic              ap_ovf,
  input  logic [ADDR_W-1:0] n,
  input  logic [ADDR_W-1:0] a_base,
  input  logic [ADDR_W-1:0] b_base,
  input  logic              sat_en,
  output logic [ADDR_W-1:0] a_address0,
  output logic              a_ce0,
  output logic              a_we0,
  output logic [DATA_W-1:0] a_ad0,
  input  logic [DATA_W-1:0] a_q0,
  output logic [ADDR_W-1:0] b_address0,
  output logic              b_ce0,
  output logic              b_we0,
  output logic [DATA_W-1:0] b_ad0,
  input  logic [DATA_W-1:0] b_q0
);

  localparam int PW = 2 * DATA_W;
  localparam int XW = ACC_W + 1 - PW;
  localparam bit SX = (SIGNED != 0);
  localparam logic [ADDR_W-1:0] A_ONE = ADDR_W'(1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t            state;
  logic [ADDR_W-1:0] n_r;
  logic [ADDR_W-1:0] a_base_r;
  logic [ADDR_W-1:0] b_base_r;
  logic [ADDR_W-1:0] idx;
  logic              sat_r;
  logic              valid;
  logic [ACC_W-1:0]  acc;
  logic              ovf_r;

  logic [PW-1:0]     a_ext;
  logic [PW-1:0]     b_ext;
  logic [PW-1:0]     prod;
  logic [ACC_W:0]    prod_ext;
  logic [ACC_W:0]    acc_ext;
  logic [ACC_W:0]    sum;
  logic              ovf_now;
  logic [ACC_W-1:0]  clamp;
  logic [ACC_W-1:0]  acc_nxt;
  logic              ovf_nxt;
  logic              accept;

  assign accept = (state == S_IDLE) && ap_start;

  assign a_ce0 = (state == S_RUN);
  assign b_ce0 = (state == S_RUN);
  assign a_address0 = a_ce0 ? a_base_r + idx : '0;
  assign b_address0 = b_ce0 ? b_base_r + idx : '0;
  assign a_we0 = 1'b0;
  assign b_we0 = 1'b0;
  assign a_ad0 = '0;
  assign b_ad0 = '0;

  // Product, extension and saturating/wrapping sum for one element pair
  always_comb begin
    a_ext = {{DATA_W{SX & a_q0[DATA_W-1]}}, a_q0};
    b_ext = {{DATA_W{SX & b_q0[DATA_W-1]}}, b_q0};
    prod = a_ext * b_ext;
    prod_ext = {{XW{SX & prod[PW-1]}}, prod};
    acc_ext = {SX & acc[ACC_W-1], acc};
    sum = acc_ext + prod_ext;
    if (SX) begin
      ovf_now = sum[ACC_W] ^ sum[ACC_W-1];
      clamp = sum[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}}
                         : {1'b0, {(ACC_W-1){1'b1}}};
    end else begin
      ovf_now = sum[ACC_W];
      clamp = '1;
    end
    acc_nxt = acc;
    ovf_nxt = ovf_r;
    if (valid) begin
      acc_nxt = (ovf_now && sat_r) ? clamp : sum[ACC_W-1:0];
      ovf_nxt = ovf_r | ovf_now;
    end
  end

  // Control FSM with registered handshake outputs and result capture
  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      state     <= S_IDLE;
      ap_idle   <= 1'b1;
      ap_done   <= 1'b0;
      ap_return <= '0;
      ap_ovf    <= 1'b0;
      n_r       <= '0;
      a_base_r  <= '0;
      b_base_r  <= '0;
      idx       <= '0;
      sat_r     <= 1'b0;
    end else begin
      ap_done <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (ap_start) begin
            n_r      <= n;
            a_base_r <= a_base;
            b_base_r <= b_base;
            sat_r    <= sat_en;
            idx      <= '0;
            ap_idle  <= 1'b0;
            ap_ovf   <= 1'b0;
            if (n == '0) begin
              state     <= S_DONE;
              ap_done   <= 1'b1;
              ap_return <= '0;
            end else begin
              state <= S_RUN;
            end
          end
        end
        S_RUN: begin
          if (idx == n_r - A_ONE) begin
            state <= S_DRAIN;
          end else begin
            idx <= idx + A_ONE;
          end
        end
        S_DRAIN: begin
          state     <= S_DONE;
          ap_done   <= 1'b1;
          ap_return <= acc_nxt;
          ap_ovf    <= ovf_nxt;
        end
        S_DONE: begin
          state   <= S_IDLE;
          ap_idle <= 1'b1;
        end
        default: begin
          state   <= S_IDLE;
          ap_idle <= 1'b1;
        end
      endcase
    end
  end

  // Read-data valid tracking and accumulator update
  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      valid <= 1'b0;
      acc   <= '0;
      ovf_r <= 1'b0;
    end else begin
      valid <= a_ce0;
      if (accept) begin
        acc   <= '0;
        ovf_r <= 1'b0;
      end else begin
        acc   <= acc_nxt;
        ovf_r <= ovf_nxt;
      end
    end
  end

endmodule

// File: tb/tb_dotprod_acc.sv
// tb_dotprod_acc: directed vectors for two dotprod_acc builds.
// Wide unsigned build and narrow signed build with 4-bit addresses.
module tb_dotprod_acc;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk = 0;
  int n_pass = 0;

  task automatic check(input string tag,
                       input logic [63:0] got,
                       input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // wide build: 32-bit data/address, 64-bit acc, unsigned
  logic        w_rst, w_start, w_idle, w_done, w_ovf, w_sat;
  logic [63:0] w_ret;
  logic [31:0] w_n, w_ab, w_bb, w_aa, w_ba, w_aad, w_bad;
  logic [31:0] w_aq, w_bq;
  logic        w_ace, w_bce, w_awe, w_bwe;
  logic [31:0] w_amem [0:15];
  logic [31:0] w_bmem [0:15];
  logic [31:0] w_alog [$];
  logic [31:0] w_blog [$];

  dotprod_acc #(
    .DATA_W(32), .ADDR_W(32), .ACC_W(64), .SIGNED(0)
  ) u_w (
    .ap_clk(clk), .ap_rst(w_rst), .ap_start(w_start),
    .ap_idle(w_idle), .ap_done(w_done), .ap_return(w_ret),
    .ap_ovf(w_ovf), .n(w_n), .a_base(w_ab), .b_base(w_bb),
    .sat_en(w_sat),
    .a_address0(w_aa), .a_ce0(w_ace), .a_we0(w_awe),
    .a_ad0(w_aad), .a_q0(w_aq),
    .b_address0(w_ba), .b_ce0(w_bce), .b_we0(w_bwe),
    .b_ad0(w_bad), .b_q0(w_bq)
  );

  // wide build SRAMs
  always @(posedge clk) begin
    if (w_ace) w_aq <= w_amem[w_aa[3:0]];
    if (w_bce) w_bq <= w_bmem[w_ba[3:0]];
  end

  // narrow build: 8-bit data, 4-bit address, 16-bit acc, signed
  logic        s_rst, s_start, s_idle, s_done, s_ovf, s_sat;
  logic [15:0] s_ret;
  logic [3:0]  s_n, s_ab, s_bb, s_aa, s_ba;
  logic [7:0]  s_aad, s_bad, s_aq, s_bq;
  logic        s_ace, s_bce, s_awe, s_bwe;
  logic [7:0]  s_amem [0:15];
  logic [7:0]  s_bmem [0:15];
  logic [3:0]  s_alog [$];
  logic [3:0]  s_blog [$];

  dotprod_acc #(
    .DATA_W(8), .ADDR_W(4), .ACC_W(16), .SIGNED(1)
  ) u_s (
    .ap_clk(clk), .ap_rst(s_rst), .ap_start(s_start),
    .ap_idle(s_idle), .ap_done(s_done), .ap_return(s_ret),
    .ap_ovf(s_ovf), .n(s_n), .a_base(s_ab), .b_base(s_bb),
    .sat_en(s_sat),
    .a_address0(s_aa), .a_ce0(s_ace), .a_we0(s_awe),
    .a_ad0(s_aad), .a_q0(s_aq),
    .b_address0(s_ba), .b_ce0(s_bce), .b_we0(s_bwe),
    .b_ad0(s_bad), .b_q0(s_bq)
  );

  // narrow build SRAMs
  always @(posedge clk) begin
    if (s_ace) s_aq <= s_amem[s_aa];
    if (s_bce) s_bq <= s_bmem[s_ba];
  end

  task automatic w_call(input logic [31:0] nn,
                        input logic [31:0] ab,
                        input logic [31:0] bb,
                        input logic sat,
                        output int lat);
    @(negedge clk);
    w_n = nn; w_ab = ab; w_bb = bb; w_sat = sat; w_start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    w_start = 1'b0;
    lat = -1;
    w_alog.delete();
    w_blog.delete();
    for (int k = 1; k <= 64; k++) begin
      if (w_ace) w_alog.push_back(w_aa);
      if (w_bce) w_blog.push_back(w_ba);
      if (w_done) begin
        lat = k;
        break;
      end
      @(negedge clk);
    end
    if (lat < 0) check("w_timeout", 64'd0, 64'd1);
  endtask

  task automatic s_call(input logic [3:0] nn,
                        input logic [3:0] ab,
                        input logic [3:0] bb,
                        input logic sat,
                        output int lat);
    @(negedge clk);
    s_n = nn; s_ab = ab; s_bb = bb; s_sat = sat; s_start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    s_start = 1'b0;
    lat = -1;
    s_alog.delete();
    s_blog.delete();
    for (int k = 1; k <= 64; k++) begin
      if (s_ace) s_alog.push_back(s_aa);
      if (s_bce) s_blog.push_back(s_ba);
      if (s_done) begin
        lat = k;
        break;
      end
      @(negedge clk);
    end
    if (lat < 0) check("s_timeout", 64'd0, 64'd1);
  endtask

  initial begin
    int lat;
    int pulses;
    w_rst = 1'b1; w_start = 1'b0; w_sat = 1'b0;
    w_n = '0; w_ab = '0; w_bb = '0;
    s_rst = 1'b1; s_start = 1'b0; s_sat = 1'b0;
    s_n = '0; s_ab = '0; s_bb = '0;
    for (int i = 0; i < 16; i++) begin
      w_amem[i] = '0; w_bmem[i] = '0;
      s_amem[i] = '0; s_bmem[i] = '0;
    end
    repeat (3) @(negedge clk);
    w_rst = 1'b0;
    s_rst = 1'b0;
    @(negedge clk);

    check("rst_idle", 64'(w_idle), 64'd1);
    check("rst_done", 64'(w_done), 64'd0);
    check("rst_ret", w_ret, 64'd0);
    check("rst_ovf", 64'(w_ovf), 64'd0);
    check("rst_ce", 64'({w_ace, w_bce}), 64'd0);
    check("rst_addr", 64'(w_aa), 64'd0);
    check("rst_s_idle", 64'(s_idle), 64'd1);
    check("tie_we", 64'({w_awe, w_bwe, s_awe, s_bwe}), 64'd0);
    check("tie_ad_w", {w_aad, w_bad}, 64'd0);
    check("tie_ad_s", 64'({s_aad, s_bad}), 64'd0);

    // basic unsigned product: 1..10 . 10..1 = 220
    for (int i = 0; i < 10; i++) begin
      w_amem[i] = 32'(i + 1);
      w_bmem[i] = 32'(10 - i);
    end
    w_call(32'd10, 32'd0, 32'd0, 1'b0, lat);
    check("basic_lat", 64'(lat), 64'd12);
    check("basic_ret", w_ret, 64'd220);
    check("basic_ovf", 64'(w_ovf), 64'd0);
    check("basic_na", 64'(w_alog.size()), 64'd10);
    check("basic_nb", 64'(w_blog.size()), 64'd10);
    for (int i = 0; i < 10 && i < w_alog.size(); i++)
      check("basic_aaddr", 64'(w_alog[i]), 64'(i));
    for (int i = 0; i < 10 && i < w_blog.size(); i++)
      check("basic_baddr", 64'(w_blog[i]), 64'(i));
    repeat (3) @(negedge clk);
    check("hold_ret", w_ret, 64'd220);
    check("hold_idle", 64'(w_idle), 64'd1);
    check("hold_done", 64'(w_done), 64'd0);

    // signed: (-3 x4) . (5 x4) = -60
    for (int i = 0; i < 4; i++) begin
      s_amem[i] = 8'hFD;
      s_bmem[i] = 8'd5;
    end
    s_call(4'd4, 4'd0, 4'd0, 1'b0, lat);
    check("sgn_lat", 64'(lat), 64'd6);
    check("sgn_ret", 64'(s_ret), 64'h0000_FFC4);
    check("sgn_ovf", 64'(s_ovf), 64'd0);

    // 3 x 127*127 = 48387 overflows a 16-bit signed acc
    for (int i = 0; i < 3; i++) begin
      s_amem[i] = 8'd127;
      s_bmem[i] = 8'd127;
    end
    s_call(4'd3, 4'd0, 4'd0, 1'b1, lat);
    check("sat_ret", 64'(s_ret), 64'h0000_7FFF);
    check("sat_ovf", 64'(s_ovf), 64'd1);
    s_call(4'd3, 4'd0, 4'd0, 1'b0, lat);
    check("wrap_ret", 64'(s_ret), 64'h0000_BD03);
    check("wrap_ovf", 64'(s_ovf), 64'd1);

    // address wrap: a at 14,15,0,1 ; b at 0..3 ; 2+6+12+20 = 40
    s_amem[14] = 8'd2; s_amem[15] = 8'd3;
    s_amem[0] = 8'd4;  s_amem[1] = 8'd5;
    for (int i = 0; i < 4; i++) s_bmem[i] = 8'(i + 1);
    s_call(4'd4, 4'd14, 4'd0, 1'b0, lat);
    check("aw_ret", 64'(s_ret), 64'd40);
    check("aw_ovf", 64'(s_ovf), 64'd0);
    check("aw_na", 64'(s_alog.size()), 64'd4);
    if (s_alog.size() == 4) begin
      check("aw_a0", 64'(s_alog[0]), 64'd14);
      check("aw_a1", 64'(s_alog[1]), 64'd15);
      check("aw_a2", 64'(s_alog[2]), 64'd0);
      check("aw_a3", 64'(s_alog[3]), 64'd1);
    end
    for (int i = 0; i < 4 && i < s_blog.size(); i++)
      check("aw_baddr", 64'(s_blog[i]), 64'(i));

    // zero length, start held high across done: second call n=3 -> 52
    @(negedge clk);
    w_n = 32'd0; w_ab = 32'd0; w_bb = 32'd0; w_start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("z_done", 64'(w_done), 64'd1);
    check("z_ret", w_ret, 64'd0);
    check("z_ce", 64'(w_ace), 64'd0);
    w_n = 32'd3;
    @(negedge clk);
    check("rs_idle", 64'(w_idle), 64'd1);
    check("rs_done", 64'(w_done), 64'd0);
    @(negedge clk);
    check("rs_busy", 64'(w_idle), 64'd0);
    check("rs_ce", 64'(w_ace), 64'd1);
    check("rs_addr", 64'(w_aa), 64'd0);
    w_start = 1'b0;
    lat = -1;
    for (int k = 0; k <= 20; k++) begin
      if (w_done) begin
        lat = k;
        break;
      end
      @(negedge clk);
    end
    check("rs_lat", 64'(lat), 64'd4);
    check("rs_ret", w_ret, 64'd52);

    // reset in the middle of a 10-element run
    @(negedge clk);
    w_n = 32'd10; w_ab = 32'd0; w_bb = 32'd0; w_start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    w_start = 1'b0;
    repeat (4) @(negedge clk);
    check("mr_ce", 64'(w_ace), 64'd1);
    check("mr_addr", 64'(w_aa), 64'd4);
    w_rst = 1'b1;
    @(negedge clk);
    w_rst = 1'b0;
    check("mr_idle", 64'(w_idle), 64'd1);
    check("mr_ce0", 64'({w_ace, w_bce}), 64'd0);
    check("mr_addr0", {w_aa, w_ba}, 64'd0);
    check("mr_ret", w_ret, 64'd0);
    check("mr_done", 64'(w_done), 64'd0);
    pulses = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (w_done) pulses++;
    end
    check("mr_nodone", 64'(pulses), 64'd0);
    w_call(32'd10, 32'd0, 32'd0, 1'b0, lat);
    check("mr2_lat", 64'(lat), 64'd12);
    check("mr2_ret", w_ret, 64'd220);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
